serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor step per clock, LSB first.
// Result, final borrow and zero flag are published together when the last bit completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  // Counts 0..WIDTH, so it never wraps inside an operation.
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             borrow_out_q, borrow_out_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic bit_x, bit_y, bit_d, bit_br_next;

  // Full-subtractor slice on the current LSBs and the running borrow.
  always_comb begin
    bit_x       = a_sh_q[0];
    bit_y       = b_sh_q[0];
    bit_d       = bit_x ^ bit_y ^ borrow_q;
    bit_br_next = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & borrow_q);
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        a_sh_d            = a_sh_q >> 1;
        b_sh_d            = b_sh_q >> 1;
        // Each new difference bit enters at the MSB; after WIDTH shifts bit 0 is in place.
        res_d             = res_q >> 1;
        res_d[WIDTH-1]    = bit_d;
        borrow_d          = bit_br_next;
        cnt_d             = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d      = DONE;
          diff_d       = res_d;
          borrow_out_d = bit_br_next;
          zero_d       = (res_d == '0);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
    end
  end

  assign ready      = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1, compared
// against plain unsigned arithmetic.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       rst_n8, start8, ready8, busy8, done8, borrow8, zero8;
  logic [7:0] a8, b8, diff8;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n8), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8),
    .diff(diff8), .borrow_out(borrow8), .zero(zero8)
  );

  // WIDTH=1 instance
  logic rst_n1, start1, ready1, busy1, done1, borrow1, zero1;
  logic [0:0] a1, b1, diff1;

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n1), .start(start1), .a(a1), .b(b1),
    .ready(ready1), .busy(busy1), .done(done1),
    .diff(diff1), .borrow_out(borrow1), .zero(zero1)
  );

  int checks   = 0;
  int failures = 0;

  // Last published result of the WIDTH=8 instance, as the model expects it.
  logic [7:0] held_diff;
  logic       held_borrow, held_zero;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] held_vec();
    return {22'd0, held_zero, held_borrow, held_diff};
  endfunction

  // Called at posedge+1 with dut8 in IDLE. junk_cyc in 1..7 pulses a spurious
  // start with other operands during that RUN cycle (0 = none).
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input int junk_cyc);
    logic [7:0] exp_diff;
    logic       exp_borrow;
    exp_diff   = ta - tb_;
    exp_borrow = (ta < tb_);
    a8 = ta; b8 = tb_; start8 = 1'b1;
    @(posedge clk); #1;                       // E0
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);     // must not matter any more
    check("busy_e0", {31'd0, busy8}, 32'd1);
    for (int k = 1; k < 8; k++) begin
      if (k == junk_cyc) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      check("busy_run", {30'd0, busy8, done8}, 32'd2);
      check("hold_run", {22'd0, zero8, borrow8, diff8}, held_vec());
    end
    start8 = 1'b0;
    @(posedge clk); #1;                       // WIDTH edges after E0
    check("done_pulse", {29'd0, ready8, busy8, done8}, 32'd1);
    check("diff", {24'd0, diff8}, {24'd0, exp_diff});
    check("borrow", {31'd0, borrow8}, {31'd0, exp_borrow});
    check("zero", {31'd0, zero8}, {31'd0, (exp_diff == 8'd0)});
    held_diff = exp_diff; held_borrow = exp_borrow; held_zero = (exp_diff == 8'd0);
    @(posedge clk); #1;
    check("after_done", {29'd0, ready8, busy8, done8}, 32'd4);
  endtask

  task automatic idle8(input int n);
    for (int k = 0; k < n; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'b0;
      @(posedge clk); #1;
      check("hold_idle", {22'd0, zero8, borrow8, diff8}, held_vec());
      check("ready_idle", {31'd0, ready8}, 32'd1);
    end
  endtask

  // Start an operation, then assert reset asynchronously in RUN cycle 4.
  task automatic abort8(input logic [7:0] ta, input logic [7:0] tb_);
    a8 = ta; b8 = tb_; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
    end
    #2 rst_n8 = 1'b0;
    #1;
    check("rst_async_state", {29'd0, ready8, busy8, done8}, 32'd4);
    check("rst_async_out", {22'd0, zero8, borrow8, diff8}, 32'h200);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("rst_no_done", {31'd0, done8}, 32'd0);
    end
    #2 rst_n8 = 1'b1;
    held_diff = 8'd0; held_borrow = 1'b0; held_zero = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic op1(input logic ta, input logic tb_);
    a1 = ta; b1 = tb_; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    a1 = ~ta; b1 = ~tb_;
    check("w1_busy", {29'd0, ready1, busy1, done1}, 32'd2);
    @(posedge clk); #1;
    check("w1_done", {29'd0, ready1, busy1, done1}, 32'd1);
    check("w1_result", {30'd0, diff1, borrow1}, {30'd0, ta ^ tb_, ~ta & tb_});
    check("w1_zero", {31'd0, zero1}, {31'd0, ~(ta ^ tb_)});
    @(posedge clk); #1;
    check("w1_idle", {29'd0, ready1, busy1, done1}, 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n8 = 1'b0; rst_n1 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    held_diff = 8'd0; held_borrow = 1'b0; held_zero = 1'b1;
    #12;
    check("rst_state8", {29'd0, ready8, busy8, done8}, 32'd4);
    check("rst_out8", {22'd0, zero8, borrow8, diff8}, 32'h200);
    check("rst_state1", {29'd0, ready1, busy1, done1}, 32'd4);
    check("rst_out1", {30'd0, zero1, borrow1, diff1}, 32'h4);
    #1 rst_n8 = 1'b1; rst_n1 = 1'b1;
    @(posedge clk); #1;

    op8(8'h05, 8'h03, 0);
    op8(8'h03, 8'h05, 0);
    op8(8'h00, 8'h00, 0);
    op8(8'h00, 8'hFF, 0);
    idle8(3);
    op8(8'h80, 8'h01, 3);
    abort8(8'h5A, 8'h33);
    op8(8'h10, 8'h01, 0);
    op8(8'hFF, 8'h00, 0);
    op8(8'h7F, 8'h80, 0);

    for (int n = 0; n < 30; n++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? ra : 8'($urandom);
      op8(ra, rb, int'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) idle8(int'($urandom_range(1, 3)));
    end

    for (int rep = 0; rep < 2; rep++) begin
      for (int v = 0; v < 4; v++) begin
        logic [1:0] ab;
        ab = 2'(v);
        op1(ab[1], ab[0]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
